// File: rtl/sub_pkg.sv
// -----------------------------------------------------------------------------
// sub_pkg
// Shared definitions for the pipelined subtractor pipesub32_4:
//   - default operand width and pipeline depth
//   - the per-stage pipeline record (valid, resolved diff bits, running carry,
//     unconsumed operand slices, operand sign bits for the overflow check)
//   - flush/stall priority encoding and its decode function
// -----------------------------------------------------------------------------
package sub_pkg;

  localparam int WIDTH_DEF  = 32;
  localparam int STAGES_DEF = 4;

  // One pipeline stage. a_hi/b_hi shift right by one slice per stage, so the
  // slice to consume next always sits in the low bits.
  typedef struct packed {
    logic                 valid;
    logic [WIDTH_DEF-1:0] partial_diff;
    logic                 carry;
    logic [WIDTH_DEF-1:0] a_hi;
    logic [WIDTH_DEF-1:0] b_hi;
    logic                 a_msb;
    logic                 b_msb;
  } stage_t;

  // Pipeline control actions, in priority order: flush beats stall.
  localparam logic [1:0] CTL_ADVANCE = 2'd0;
  localparam logic [1:0] CTL_STALL   = 2'd1;
  localparam logic [1:0] CTL_FLUSH   = 2'd2;

  function automatic logic [1:0] pipe_ctl(input logic flush, input logic stall);
    if (flush) return CTL_FLUSH;
    if (stall) return CTL_STALL;
    return CTL_ADVANCE;
  endfunction

endpackage

// File: rtl/sub_slice.sv
// -----------------------------------------------------------------------------
// sub_slice
// Combinational W-bit slice of a two's-complement subtractor: a + ~b + cin.
// A carry of 1 means "no borrow".
//   a_i    : minuend slice
//   b_i    : subtrahend slice (inverted internally)
//   cin_i  : carry-in (inverse of borrow-in)
//   sum_o  : difference slice
//   cout_o : carry-out to the next slice
// -----------------------------------------------------------------------------
module sub_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  logic [W:0] sum_ext;

  assign sum_ext = {1'b0, a_i} + {1'b0, ~b_i} + {{W{1'b0}}, cin_i};
  assign sum_o   = sum_ext[W-1:0];
  assign cout_o  = sum_ext[W];

endmodule

// File: rtl/pipesub32_4.sv
// -----------------------------------------------------------------------------
// pipesub32_4
// 32-bit subtractor (diff = a - b - bin) pipelined as 4 slices of 8 bits.
// Stage k resolves bits [k*SLICE +: SLICE]; the result leaves the last stage
// register, so an operation accepted on edge N is presented after edge N+3.
// The stage record is sized by the package defaults; retarget the width or
// depth by changing WIDTH_DEF/STAGES_DEF.
//   clk         : rising-edge clock
//   rst_n       : asynchronous active-low reset
//   a_i, b_i    : minuend, subtrahend
//   bin_i       : borrow-in
//   in_valid_i  : operands valid this cycle
//   stop_i      : stall, every stage holds and the input is ignored
//   new_i       : flush, all in-flight operations are discarded (beats stop_i)
//   diff_o      : a - b - bin modulo 2^WIDTH
//   bout_o      : borrow-out
//   ovf_o       : signed overflow
//   out_valid_o : outputs valid
// -----------------------------------------------------------------------------
module pipesub32_4
  import sub_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int STAGES = STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             bin_i,
  input  logic             in_valid_i,
  input  logic             stop_i,
  input  logic             new_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             bout_o,
  output logic             ovf_o,
  output logic             out_valid_o
);

  localparam int SLICE = WIDTH / STAGES;

  stage_t            stage_q   [STAGES];
  stage_t            stage_d   [STAGES];
  stage_t            head;
  stage_t            last;
  logic [SLICE-1:0]  slice_a   [STAGES];
  logic [SLICE-1:0]  slice_b   [STAGES];
  logic [SLICE-1:0]  slice_sum [STAGES];
  logic              slice_cin [STAGES];
  logic              slice_cout[STAGES];

  // Record fed into stage 0: the operands straight from the ports. Borrow-in
  // becomes the inverted carry-in of the lowest slice.
  always_comb begin
    head              = '0;
    head.valid        = in_valid_i;
    head.carry        = ~bin_i;
    head.a_hi         = a_i;
    head.b_hi         = b_i;
    head.a_msb        = a_i[WIDTH-1];
    head.b_msb        = b_i[WIDTH-1];
  end

  // Slice inputs: stage k consumes the low slice of whatever stage k-1 holds.
  always_comb begin
    stage_t src;
    src = head;
    for (int k = 0; k < STAGES; k++) begin
      slice_a[k]   = src.a_hi[SLICE-1:0];
      slice_b[k]   = src.b_hi[SLICE-1:0];
      slice_cin[k] = src.carry;
      src          = stage_q[k];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    sub_slice #(.W(SLICE)) u_slice (
      .a_i    (slice_a[k]),
      .b_i    (slice_b[k]),
      .cin_i  (slice_cin[k]),
      .sum_o  (slice_sum[k]),
      .cout_o (slice_cout[k])
    );
  end

  // Next-state records: pass the previous record along, drop in the newly
  // resolved slice, and shift the consumed operand slice out.
  always_comb begin
    stage_t src;
    src = head;
    for (int k = 0; k < STAGES; k++) begin
      stage_d[k]                                = src;
      stage_d[k].partial_diff[k*SLICE +: SLICE] = slice_sum[k];
      stage_d[k].carry                          = slice_cout[k];
      stage_d[k].a_hi                           = src.a_hi >> SLICE;
      stage_d[k].b_hi                           = src.b_hi >> SLICE;
      src                                       = stage_q[k];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its predecessor's pre-edge value; blocking here would collapse
  // the pipeline into a single cycle.
  // NOTE: data fields are reset along with the valid bits because the reset
  // state of diff/bout/ovf is observable, not just out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) stage_q[k] <= '0;
    end else begin
      case (pipe_ctl(new_i, stop_i))
        CTL_FLUSH: begin
          for (int k = 0; k < STAGES; k++) stage_q[k].valid <= 1'b0;
        end
        CTL_STALL: begin
          // hold everything
        end
        default: begin
          for (int k = 0; k < STAGES; k++) stage_q[k] <= stage_d[k];
        end
      endcase
    end
  end

  assign last        = stage_q[STAGES-1];
  assign diff_o      = last.partial_diff;
  assign out_valid_o = last.valid;
  // Gated by valid so the cleared (carry=0) reset state reads as no borrow.
  assign bout_o      = last.valid & ~last.carry;
  // Overflow only when operand signs differ and the result sign left a's.
  assign ovf_o       = (last.a_msb ^ last.b_msb) & (last.partial_diff[WIDTH-1] ^ last.a_msb);

endmodule

// File: tb/tb_pipesub32_4.sv
// -----------------------------------------------------------------------------
// tb_pipesub32_4
// Self-checking bench for pipesub32_4. A reference model keeps the accepted
// operations in a queue with their age in unstalled edges; an operation whose
// age reaches 4 is the expected output. Results are computed with plain
// integer arithmetic on the whole operands.
// -----------------------------------------------------------------------------
module tb_pipesub32_4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a, b;
  logic        bin, in_valid, stop, flush;
  logic [31:0] diff;
  logic        bout, ovf, out_valid;

  pipesub32_4 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a_i         (a),
    .b_i         (b),
    .bin_i       (bin),
    .in_valid_i  (in_valid),
    .stop_i      (stop),
    .new_i       (flush),
    .diff_o      (diff),
    .bout_o      (bout),
    .ovf_o       (ovf),
    .out_valid_o (out_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          age;
    logic [31:0] d;
    logic        bo;
    logic        ov;
  } op_t;

  op_t         inflight[$];
  logic        exp_valid;
  logic [31:0] exp_d;
  logic        exp_bo, exp_ov;

  function automatic op_t ref_op(input logic [31:0] av, input logic [31:0] bv, input logic bi);
    op_t    r;
    longint sa, sb, sr;
    logic [63:0] ua, ub;
    ua   = {32'b0, av};
    ub   = {32'b0, bv} + {63'b0, bi};
    r.d  = av - bv - {31'b0, bi};
    r.bo = (ua < ub);
    sa   = longint'($signed(av));
    sb   = longint'($signed(bv));
    sr   = sa - sb - longint'(bi);
    r.ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    r.age = 1;
    return r;
  endfunction

  task automatic model_reset();
    inflight.delete();
    exp_valid = 1'b0;
    exp_d     = '0;
    exp_bo    = 1'b0;
    exp_ov    = 1'b0;
  endtask

  // Called right after each rising edge with the inputs the DUT just sampled.
  task automatic model_edge();
    if (flush) begin
      inflight.delete();
      exp_valid = 1'b0;
    end else if (!stop) begin
      foreach (inflight[i]) inflight[i].age++;
      if (in_valid) inflight.push_back(ref_op(a, b, bin));
      exp_valid = 1'b0;
      if (inflight.size() > 0 && inflight[0].age == 4) begin
        op_t o;
        o = inflight.pop_front();
        exp_valid = 1'b1;
        exp_d     = o.d;
        exp_bo    = o.bo;
        exp_ov    = o.ov;
      end
    end
  endtask

  task automatic compare_outputs();
    check("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
    if (exp_valid) begin
      check("diff", diff, exp_d);
      check("bout", {31'b0, bout}, {31'b0, exp_bo});
      check("ovf",  {31'b0, ovf},  {31'b0, exp_ov});
    end
  endtask

  // One clock: drive at negedge, model at posedge, compare at next negedge.
  task automatic cycle(input logic [31:0] av, input logic [31:0] bv, input logic bi,
                       input logic iv, input logic st, input logic nw);
    a = av; b = bv; bin = bi; in_valid = iv; stop = st; flush = nw;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle('0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic check_zero_outputs(input string tag);
    check({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_diff"},      diff,               32'd0);
    check({tag, "_bout"},      {31'b0, bout},      32'd0);
    check({tag, "_ovf"},       {31'b0, ovf},       32'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rbin;

    rst_n = 1'b0; a = '0; b = '0; bin = 1'b0;
    in_valid = 1'b0; stop = 1'b0; flush = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;

    // Basic, full borrow ripple, overflow, equal operands with borrow-in.
    cycle(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(4);
    cycle(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(32'h34AA_F8D5, 32'h34AA_F8D5, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(4);

    // Six back-to-back ops with a 2-cycle stall while three are in flight;
    // the sender holds op 4 during the stall and re-presents it.
    for (int i = 0; i < 3; i++) cycle(rand_word(), rand_word(), 1'($urandom), 1'b1, 1'b0, 1'b0);
    ra = rand_word(); rb = rand_word(); rbin = 1'($urandom);
    cycle(ra, rb, rbin, 1'b1, 1'b1, 1'b0);
    cycle(ra, rb, rbin, 1'b1, 1'b1, 1'b0);
    cycle(ra, rb, rbin, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) cycle(rand_word(), rand_word(), 1'($urandom), 1'b1, 1'b0, 1'b0);
    idle(5);

    // Flush with three in flight and an op presented on the flush cycle
    // (stop also high to show flush wins).
    for (int i = 0; i < 3; i++) cycle(rand_word(), rand_word(), 1'($urandom), 1'b1, 1'b0, 1'b0);
    cycle(rand_word(), rand_word(), 1'b0, 1'b1, 1'b1, 1'b1);
    idle(4);
    for (int i = 0; i < 2; i++) cycle(rand_word(), rand_word(), 1'($urandom), 1'b1, 1'b0, 1'b0);
    idle(4);

    // Asynchronous reset between edges with operations in flight.
    for (int i = 0; i < 2; i++) cycle(rand_word(), rand_word(), 1'($urandom), 1'b1, 1'b0, 1'b0);
    a = rand_word(); b = rand_word(); bin = 1'b0; in_valid = 1'b1; stop = 1'b0; flush = 1'b0;
    @(posedge clk);
    model_edge();
    #2 rst_n = 1'b0;
    #1 check_zero_outputs("async_reset");
    model_reset();
    @(negedge clk);
    compare_outputs();
    rst_n = 1'b1;
    cycle(32'h1234_5678, 32'h0000_0678, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(4);

    // Randomized traffic with bubbles, stalls and flushes.
    for (int i = 0; i < 400; i++) begin
      cycle(rand_word(), rand_word(), 1'($urandom),
            ($urandom_range(0, 9) < 8),
            ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 19) == 0));
    end
    idle(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
